// File: rtl/uart_xmt_frame_reg.sv
// UART transmit framing block: double-buffered holding register feeding a
// FRAME_LEN-bit shift engine that is paced by an external baud tick.
// Frames go out LSB first: start 0, data, optional parity, stop ones.
module uart_xmt_frame_reg #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned PARITY_MODE = 0,  // 0 none, 1 even, 2 odd
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data_bus,
  input  logic                  i_load_xmt_register,
  input  logic                  i_bit_tick,
  input  logic                  i_clear_overrun,
  output logic                  o_serial_out,
  output logic                  o_xmt_busy,
  output logic                  o_hold_empty,
  output logic                  o_overrun
);

  localparam int unsigned ParBits  = (PARITY_MODE != 0) ? 1 : 0;
  localparam int unsigned FrameLen = 1 + DATA_WIDTH + ParBits + STOP_BITS;
  localparam int unsigned CntW     = $clog2(FrameLen + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e                r_state, w_state_nxt;
  logic [FrameLen-1:0]   r_shift, w_shift_nxt;
  logic [CntW-1:0]       r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_hold, w_hold_nxt;
  logic                  r_hold_empty, w_hold_empty_nxt;
  logic                  r_overrun, w_overrun_nxt;
  logic [FrameLen-1:0]   w_frame;

  // Out-of-range parameters are a configuration error; flag them in simulation.
  always_ff @(posedge i_clk) begin
    assert (DATA_WIDTH >= 5 && DATA_WIDTH <= 9 && PARITY_MODE <= 2 &&
            STOP_BITS >= 1 && STOP_BITS <= 2)
      else $error("uart_xmt_frame_reg: illegal DATA_WIDTH/PARITY_MODE/STOP_BITS");
  end

  // Assemble the frame from the holding register; stop bits come from the '1 default.
  always_comb begin
    w_frame                = '1;
    w_frame[0]             = 1'b0;
    w_frame[DATA_WIDTH:1]  = r_hold;
    if (PARITY_MODE == 1) begin
      w_frame[DATA_WIDTH+1] = ^r_hold;
    end else if (PARITY_MODE == 2) begin
      w_frame[DATA_WIDTH+1] = ~^r_hold;
    end
  end

  // Next-state: holding register writes, overrun flag and the IDLE/SHIFT engine.
  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_cnt_nxt        = r_cnt;
    w_hold_nxt       = r_hold;
    w_hold_empty_nxt = r_hold_empty;
    w_overrun_nxt    = r_overrun;

    if (i_clear_overrun) begin
      w_overrun_nxt = 1'b0;
    end
    // A losing write sets overrun after the clear so the set wins.
    if (i_load_xmt_register) begin
      if (r_hold_empty) begin
        w_hold_nxt       = i_data_bus;
        w_hold_empty_nxt = 1'b0;
      end else begin
        w_overrun_nxt = 1'b1;
      end
    end

    unique case (r_state)
      StIdle: begin
        // Write and transfer cannot both touch hold_empty: a write is only
        // accepted when empty, a transfer only happens when full.
        if (!r_hold_empty) begin
          w_shift_nxt      = w_frame;
          w_hold_empty_nxt = 1'b1;
          w_cnt_nxt        = '0;
          w_state_nxt      = StShift;
        end
      end
      StShift: begin
        if (i_bit_tick) begin
          w_shift_nxt = {1'b1, r_shift[FrameLen-1:1]};
          w_cnt_nxt   = r_cnt + CntW'(1);
          if (r_cnt == CntW'(FrameLen - 1)) begin
            w_state_nxt = StIdle;
          end
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State registers; reset abandons any frame and drives the line high at once.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_shift      <= '1;
      r_cnt        <= '0;
      r_hold       <= '0;
      r_hold_empty <= 1'b1;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_cnt        <= w_cnt_nxt;
      r_hold       <= w_hold_nxt;
      r_hold_empty <= w_hold_empty_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  // The shift register is all ones whenever idle, so bit 0 is the line itself.
  assign o_serial_out = r_shift[0];
  assign o_xmt_busy   = (r_state == StShift);
  assign o_hold_empty = r_hold_empty;
  assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_uart_xmt_frame_reg.sv
// Bench for uart_xmt_frame_reg: four configurations (8N1, 8E1, 8O1, 7N2) share
// one stimulus; a monitor records the line at every bit tick and each test
// compares the recorded bits against frames built from the framing rules.
module tb_uart_xmt_frame_reg;

  localparam int NumDut   = 4;
  localparam int TickDiv  = 16;
  localparam int MonDepth = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic       tick = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] data = 8'h00;
  logic [3:0] so, busy, hempty, ovr;

  int checks = 0;
  int failures = 0;

  bit [MonDepth-1:0] mon_bits [NumDut];
  int mon_cnt      [NumDut] = '{default: 0};
  int gap_cnt      [NumDut] = '{default: 0};
  int low_idle_cnt [NumDut] = '{default: 0};

  uart_xmt_frame_reg #(.DATA_WIDTH(8), .PARITY_MODE(0), .STOP_BITS(1)) u_dut_8n1 (
    .i_clk(clk), .i_rst(rst), .i_data_bus(data), .i_load_xmt_register(load),
    .i_bit_tick(tick), .i_clear_overrun(clr), .o_serial_out(so[0]),
    .o_xmt_busy(busy[0]), .o_hold_empty(hempty[0]), .o_overrun(ovr[0]));

  uart_xmt_frame_reg #(.DATA_WIDTH(8), .PARITY_MODE(1), .STOP_BITS(1)) u_dut_8e1 (
    .i_clk(clk), .i_rst(rst), .i_data_bus(data), .i_load_xmt_register(load),
    .i_bit_tick(tick), .i_clear_overrun(clr), .o_serial_out(so[1]),
    .o_xmt_busy(busy[1]), .o_hold_empty(hempty[1]), .o_overrun(ovr[1]));

  uart_xmt_frame_reg #(.DATA_WIDTH(8), .PARITY_MODE(2), .STOP_BITS(1)) u_dut_8o1 (
    .i_clk(clk), .i_rst(rst), .i_data_bus(data), .i_load_xmt_register(load),
    .i_bit_tick(tick), .i_clear_overrun(clr), .o_serial_out(so[2]),
    .o_xmt_busy(busy[2]), .o_hold_empty(hempty[2]), .o_overrun(ovr[2]));

  uart_xmt_frame_reg #(.DATA_WIDTH(7), .PARITY_MODE(0), .STOP_BITS(2)) u_dut_7n2 (
    .i_clk(clk), .i_rst(rst), .i_data_bus(data[6:0]), .i_load_xmt_register(load),
    .i_bit_tick(tick), .i_clear_overrun(clr), .o_serial_out(so[3]),
    .o_xmt_busy(busy[3]), .o_hold_empty(hempty[3]), .o_overrun(ovr[3]));

  always #5 clk = ~clk;

  // Free-running baud tick, one clock wide every TickDiv clocks.
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tc == TickDiv - 1);
      tc = (tc + 1) % TickDiv;
    end
  end

  // Monitor: the bit on the line at a tick cycle is the bit that tick retires.
  always @(negedge clk) begin
    for (int i = 0; i < NumDut; i++) begin
      if (tick && busy[i] && !rst) begin
        if (mon_cnt[i] < MonDepth) mon_bits[i][mon_cnt[i]] = so[i];
        mon_cnt[i]++;
      end
      if (!busy[i] && !hempty[i] && !rst) gap_cnt[i]++;
      if (!busy[i] && !so[i]) low_idle_cnt[i]++;
    end
  end

  // Configuration of instance c.
  function automatic int cfg_dw(input int c);
    return (c == 3) ? 7 : 8;
  endfunction

  function automatic int cfg_pm(input int c);
    return (c == 1) ? 1 : ((c == 2) ? 2 : 0);
  endfunction

  function automatic int cfg_sb(input int c);
    return (c == 3) ? 2 : 1;
  endfunction

  function automatic int flen(input int c);
    return 1 + cfg_dw(c) + ((cfg_pm(c) != 0) ? 1 : 0) + cfg_sb(c);
  endfunction

  // Reference frame, bit k = k-th bit on the line; positions past the frame are 1.
  function automatic logic [15:0] exp_frame(input int c, input logic [7:0] d);
    logic [15:0] f;
    int ones;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int k = 0; k < cfg_dw(c); k++) begin
      f[1 + k] = d[k];
      ones += int'(d[k]);
    end
    if (cfg_pm(c) == 1) f[1 + cfg_dw(c)] = ((ones % 2) == 1);
    if (cfg_pm(c) == 2) f[1 + cfg_dw(c)] = ((ones % 2) == 0);
    return f;
  endfunction

  task automatic collect(input int i, input int start, output logic [15:0] got);
    got = '1;
    for (int k = 0; k < flen(i); k++) got[k] = mon_bits[i][start + k];
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write_char(input logic [7:0] d);
    data = d;
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(busy == 4'h0 && hempty == 4'hF) && n < budget) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL wait_idle: busy=%b hold_empty=%b after %0d cycles, required idle",
               busy, hempty, budget);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(2);
    @(negedge clk);
    checks++;
    if (so !== 4'hF) begin failures++; $display("FAIL reset_serial_out: got %b want 1111", so); end
    checks++;
    if (busy !== 4'h0) begin failures++; $display("FAIL reset_busy: got %b want 0000", busy); end
    checks++;
    if (hempty !== 4'hF) begin failures++; $display("FAIL reset_hold_empty: got %b want 1111", hempty); end
    checks++;
    if (ovr !== 4'h0) begin failures++; $display("FAIL reset_overrun: got %b want 0000", ovr); end
    step(1);
    rst = 1'b0;
    step(1);
  endtask

  task automatic test_defaults;
    int s [NumDut];
    logic [15:0] got;
    for (int i = 0; i < NumDut; i++) s[i] = mon_cnt[i];
    write_char(8'hA5);
    @(negedge clk);
    checks++;
    if (hempty !== 4'h0) begin failures++; $display("FAIL capture_hold_empty: got %b want 0000", hempty); end
    checks++;
    if ({busy, so} !== 8'h0F) begin
      failures++; $display("FAIL capture_line_idle: busy=%b so=%b want 0000/1111", busy, so);
    end
    step(1);
    @(negedge clk);
    checks++;
    if (so !== 4'h0) begin failures++; $display("FAIL start_bit_latency: got %b want 0000", so); end
    checks++;
    if (busy !== 4'hF) begin failures++; $display("FAIL busy_on_transfer: got %b want 1111", busy); end
    checks++;
    if (hempty !== 4'hF) begin failures++; $display("FAIL hold_empty_on_transfer: got %b want 1111", hempty); end
    step(1);
    wait_idle(1000);
    @(negedge clk);
    checks++;
    if ({busy, so} !== 8'h0F) begin
      failures++; $display("FAIL after_frame_idle: busy=%b so=%b want 0000/1111", busy, so);
    end
    for (int i = 0; i < NumDut; i++) begin
      checks++;
      if (mon_cnt[i] - s[i] !== flen(i)) begin
        failures++;
        $display("FAIL a5_bit_periods[%0d]: got %0d want %0d", i, mon_cnt[i] - s[i], flen(i));
      end
      collect(i, s[i], got);
      checks++;
      if (got !== exp_frame(i, 8'hA5)) begin
        failures++;
        $display("FAIL a5_frame[%0d]: got %b want %b", i, got, exp_frame(i, 8'hA5));
      end
      if (i == 0) begin
        checks++;
        if (got[9:0] !== 10'b1101001010) begin
          failures++; $display("FAIL a5_8n1_literal: got %b want 1101001010", got[9:0]);
        end
      end
    end
    step(1);
  endtask

  task automatic test_frames;
    logic [7:0] dir [4] = '{8'h01, 8'h00, 8'h41, 8'hFF};
    logic [7:0] d;
    logic [15:0] got;
    int s [NumDut];
    for (int n = 0; n < 10; n++) begin
      d = (n < 4) ? dir[n] : 8'($urandom);
      for (int i = 0; i < NumDut; i++) s[i] = mon_cnt[i];
      write_char(d);
      step(1);
      wait_idle(1000);
      @(negedge clk);
      checks++;
      if (so !== 4'hF) begin failures++; $display("FAIL frame_idle_line %h: got %b want 1111", d, so); end
      for (int i = 0; i < NumDut; i++) begin
        collect(i, s[i], got);
        checks++;
        if (mon_cnt[i] - s[i] !== flen(i) || got !== exp_frame(i, d)) begin
          failures++;
          $display("FAIL frame %h [%0d]: got %0d bits %b want %0d bits %b",
                   d, i, mon_cnt[i] - s[i], got, flen(i), exp_frame(i, d));
        end
        if (i == 2 && n < 2) begin
          checks++;
          if (got[9] !== (n == 1)) begin
            failures++; $display("FAIL odd_parity %h: got %b want %b", d, got[9], (n == 1));
          end
        end
        if (i == 3 && n == 2) begin
          checks++;
          if (got[9:0] !== 10'b1110000010) begin
            failures++; $display("FAIL 7n2_literal: got %b want 1110000010", got[9:0]);
          end
        end
      end
      step(1);
    end
  endtask

  task automatic test_back_to_back;
    int s [NumDut];
    int g [NumDut];
    logic [15:0] got;
    for (int i = 0; i < NumDut; i++) begin s[i] = mon_cnt[i]; g[i] = gap_cnt[i]; end
    write_char(8'h11);
    step(1);
    write_char(8'h22);
    @(negedge clk);
    checks++;
    if ({hempty, ovr} !== 8'h00) begin
      failures++; $display("FAIL second_write_accepted: hold_empty=%b ovr=%b want 0000/0000", hempty, ovr);
    end
    step(1);
    write_char(8'h33);
    @(negedge clk);
    checks++;
    if (ovr !== 4'hF) begin failures++; $display("FAIL overrun_set: got %b want 1111", ovr); end
    step(1);
    wait_idle(2000);
    for (int i = 0; i < NumDut; i++) begin
      checks++;
      if (mon_cnt[i] - s[i] !== 2 * flen(i)) begin
        failures++;
        $display("FAIL b2b_bits[%0d]: got %0d want %0d", i, mon_cnt[i] - s[i], 2 * flen(i));
      end
      collect(i, s[i], got);
      checks++;
      if (got !== exp_frame(i, 8'h11)) begin
        failures++; $display("FAIL b2b_first[%0d]: got %b want %b", i, got, exp_frame(i, 8'h11));
      end
      collect(i, s[i] + flen(i), got);
      checks++;
      if (got !== exp_frame(i, 8'h22)) begin
        failures++; $display("FAIL b2b_second[%0d]: got %b want %b", i, got, exp_frame(i, 8'h22));
      end
      checks++;
      if (gap_cnt[i] - g[i] !== 2) begin
        failures++; $display("FAIL b2b_gap[%0d]: got %0d cycles want 2", i, gap_cnt[i] - g[i]);
      end
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr !== 4'h0) begin failures++; $display("FAIL overrun_cleared: got %b want 0000", ovr); end
    step(1);
  endtask

  task automatic test_simultaneous;
    int s [NumDut];
    logic [15:0] got;
    for (int i = 0; i < NumDut; i++) s[i] = mon_cnt[i];
    data = 8'h3C;
    load = 1'b1;
    step(1);
    data = 8'hE7;
    step(1);
    load = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr !== 4'hF) begin failures++; $display("FAIL transfer_edge_overrun: got %b want 1111", ovr); end
    checks++;
    if ({busy, hempty} !== 8'hFF) begin
      failures++; $display("FAIL transfer_edge_state: busy=%b hold_empty=%b want 1111/1111", busy, hempty);
    end
    step(1);
    wait_idle(1000);
    for (int i = 0; i < NumDut; i++) begin
      collect(i, s[i], got);
      checks++;
      if (mon_cnt[i] - s[i] !== flen(i) || got !== exp_frame(i, 8'h3C)) begin
        failures++;
        $display("FAIL transfer_edge_frame[%0d]: got %0d bits %b want %0d bits %b",
                 i, mon_cnt[i] - s[i], got, flen(i), exp_frame(i, 8'h3C));
      end
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr !== 4'h0) begin failures++; $display("FAIL overrun_clear2: got %b want 0000", ovr); end
    step(1);
    for (int i = 0; i < NumDut; i++) s[i] = mon_cnt[i];
    write_char(8'h96);
    step(1);
    write_char(8'h69);
    data = 8'h0F;
    load = 1'b1;
    clr = 1'b1;
    step(1);
    load = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (ovr !== 4'hF) begin failures++; $display("FAIL set_beats_clear: got %b want 1111", ovr); end
    step(1);
    wait_idle(2000);
    for (int i = 0; i < NumDut; i++) begin
      collect(i, s[i] + flen(i), got);
      checks++;
      if (mon_cnt[i] - s[i] !== 2 * flen(i) || got !== exp_frame(i, 8'h69)) begin
        failures++;
        $display("FAIL set_clear_frames[%0d]: got %0d bits second %b want %0d bits %b",
                 i, mon_cnt[i] - s[i], got, 2 * flen(i), exp_frame(i, 8'h69));
      end
    end
    clr = 1'b1;
    step(1);
    clr = 1'b0;
  endtask

  task automatic test_reset_midframe;
    int s [NumDut];
    int n;
    logic [15:0] got;
    for (int i = 0; i < NumDut; i++) s[i] = mon_cnt[i];
    write_char(8'h5A);
    step(1);
    write_char(8'hC3);
    n = 0;
    while (mon_cnt[0] - s[0] < 4 && n < 500) begin
      step(1);
      n++;
    end
    step(2);
    @(negedge clk);
    checks++;
    if ({busy, hempty} !== 8'hF0) begin
      failures++; $display("FAIL pre_reset_state: busy=%b hold_empty=%b want 1111/0000", busy, hempty);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({so, busy, hempty, ovr} !== 16'hF0F0) begin
      failures++;
      $display("FAIL async_reset: so=%b busy=%b hold_empty=%b ovr=%b want 1111/0000/1111/0000",
               so, busy, hempty, ovr);
    end
    @(posedge clk);
    #1;
    step(2);
    rst = 1'b0;
    for (int i = 0; i < NumDut; i++) s[i] = mon_cnt[i];
    step(40);
    for (int i = 0; i < NumDut; i++) begin
      checks++;
      if (mon_cnt[i] !== s[i] || so[i] !== 1'b1) begin
        failures++; $display("FAIL no_frame_after_reset[%0d]: got %0d bits want 0", i, mon_cnt[i] - s[i]);
      end
    end
    write_char(8'h5A);
    step(1);
    wait_idle(1000);
    for (int i = 0; i < NumDut; i++) begin
      collect(i, s[i], got);
      checks++;
      if (mon_cnt[i] - s[i] !== flen(i) || got !== exp_frame(i, 8'h5A)) begin
        failures++;
        $display("FAIL post_reset_frame[%0d]: got %0d bits %b want %0d bits %b",
                 i, mon_cnt[i] - s[i], got, flen(i), exp_frame(i, 8'h5A));
      end
    end
    step(1);
  endtask

  initial begin
    step(1);
    test_reset();
    test_defaults();
    test_frames();
    test_back_to_back();
    test_simultaneous();
    test_reset_midframe();
    for (int i = 0; i < NumDut; i++) begin
      checks++;
      if (low_idle_cnt[i] !== 0) begin
        failures++; $display("FAIL idle_line_low[%0d]: got %0d cycles want 0", i, low_idle_cnt[i]);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
